// File: rtl/pe_dbuf.sv
`default_nettype none
// ============================================================================
// Module      : pe_dbuf
// Description : Systolic-array processing element with a double-buffered
//               weight (shadow/active), signed/unsigned MAC and wrap/saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_dbuf #(
    parameter int ACT_W    = 8,
    parameter int WEIGHT_W = 8,
    parameter int PSUM_W   = 32,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ACT_W-1:0]    in_act,
    input  logic                in_act_valid,
    input  logic [PSUM_W-1:0]   in_psum,
    input  logic [WEIGHT_W-1:0] in_wt,
    input  logic                in_wt_valid,
    input  logic                wt_capture,
    input  logic                wt_swap,
    output logic [ACT_W-1:0]    out_act,
    output logic                out_act_valid,
    output logic [PSUM_W-1:0]   out_psum,
    output logic [WEIGHT_W-1:0] out_wt,
    output logic                out_wt_valid,
    output logic                shadow_full,
    output logic                sat_flag
);

    localparam int EXT_W = PSUM_W + 1;

    localparam logic [PSUM_W-1:0] c_smax = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] c_smin = {1'b1, {(PSUM_W-1){1'b0}}};
    localparam logic [PSUM_W-1:0] c_umax = {PSUM_W{1'b1}};

    logic [WEIGHT_W-1:0] r_active;
    logic [WEIGHT_W-1:0] r_shadow;
    logic                r_shadow_full;
    logic [ACT_W-1:0]    r_out_act;
    logic                r_out_act_valid;
    logic [PSUM_W-1:0]   r_out_psum;
    logic [WEIGHT_W-1:0] r_out_wt;
    logic                r_out_wt_valid;
    logic                r_sat_flag;

    logic                w_capture;
    logic                w_act_sign;
    logic                w_wt_sign;
    logic                w_psum_sign;
    logic [EXT_W-1:0]    w_act_ext;
    logic [EXT_W-1:0]    w_wt_ext;
    logic [EXT_W-1:0]    w_psum_ext;
    logic [EXT_W-1:0]    w_sum;
    logic [PSUM_W-1:0]   w_psum_next;
    logic                w_sat;

    assign w_capture   = in_wt_valid & wt_capture;

    assign w_act_sign  = (SIGNED != 0) & in_act[ACT_W-1];
    assign w_wt_sign   = (SIGNED != 0) & r_active[WEIGHT_W-1];
    assign w_psum_sign = (SIGNED != 0) & in_psum[PSUM_W-1];

    assign w_act_ext   = {{(EXT_W-ACT_W){w_act_sign}}, in_act};
    assign w_wt_ext    = {{(EXT_W-WEIGHT_W){w_wt_sign}}, r_active};
    assign w_psum_ext  = {w_psum_sign, in_psum};

    // The true product needs at most ACT_W+WEIGHT_W <= PSUM_W bits, so the
    // low EXT_W bits of the modular product and sum are exact.
    assign w_sum = (w_act_ext * w_wt_ext) + w_psum_ext;

    always_comb begin
        w_psum_next = w_sum[PSUM_W-1:0];
        w_sat       = 1'b0;
        if (SATURATE != 0) begin
            if (SIGNED != 0) begin
                // Out of signed range exactly when the two top bits disagree.
                if (w_sum[PSUM_W] != w_sum[PSUM_W-1]) begin
                    w_sat       = 1'b1;
                    w_psum_next = w_sum[PSUM_W] ? c_smin : c_smax;
                end
            end else if (w_sum[PSUM_W]) begin
                w_sat       = 1'b1;
                w_psum_next = c_umax;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active        <= '0;
            r_shadow        <= '0;
            r_shadow_full   <= 1'b0;
            r_out_act       <= '0;
            r_out_act_valid <= 1'b0;
            r_out_psum      <= '0;
            r_out_wt        <= '0;
            r_out_wt_valid  <= 1'b0;
            r_sat_flag      <= 1'b0;
        end else begin
            r_out_wt       <= in_wt;
            r_out_wt_valid <= in_wt_valid;

            // Swap reads the pre-capture shadow, so capture+swap chains cleanly.
            if (wt_swap && r_shadow_full) begin
                r_active <= r_shadow;
            end
            if (w_capture) begin
                r_shadow <= in_wt;
            end
            r_shadow_full <= w_capture | (r_shadow_full & ~wt_swap);

            if (in_act_valid) begin
                r_out_act       <= in_act;
                r_out_act_valid <= 1'b1;
                r_out_psum      <= w_psum_next;
                r_sat_flag      <= w_sat;
            end else begin
                r_out_act       <= '0;
                r_out_act_valid <= 1'b0;
                r_out_psum      <= in_psum;
                r_sat_flag      <= 1'b0;
            end
        end
    end

    assign out_act       = r_out_act;
    assign out_act_valid = r_out_act_valid;
    assign out_psum      = r_out_psum;
    assign out_wt        = r_out_wt;
    assign out_wt_valid  = r_out_wt_valid;
    assign shadow_full   = r_shadow_full;
    assign sat_flag      = r_sat_flag;

endmodule
`default_nettype wire

// File: tb/tb_pe_dbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_dbuf
// Description : Self-checking bench for pe_dbuf in three arithmetic configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_dbuf;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_act;
    logic        in_act_valid;
    logic [31:0] in_psum;
    logic [7:0]  in_wt;
    logic        in_wt_valid;
    logic        wt_capture;
    logic        wt_swap;

    logic [7:0]  a_act, b_act, c_act, a_wt, b_wt, c_wt;
    logic        a_act_v, b_act_v, c_act_v, a_wt_v, b_wt_v, c_wt_v;
    logic [31:0] a_psum;
    logic [15:0] b_psum, c_psum;
    logic        a_full, b_full, c_full, a_sat, b_sat, c_sat;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] m_active, m_shadow;
    bit         m_full;

    always #5 clk = ~clk;

    // a: signed wrap 32-bit; b: signed saturate 16-bit; c: unsigned saturate 16-bit
    pe_dbuf #(.ACT_W(8), .WEIGHT_W(8), .PSUM_W(32), .SIGNED(1), .SATURATE(0)) u_dut_a (
        .clk(clk), .reset(reset), .in_act(in_act), .in_act_valid(in_act_valid),
        .in_psum(in_psum), .in_wt(in_wt), .in_wt_valid(in_wt_valid),
        .wt_capture(wt_capture), .wt_swap(wt_swap), .out_act(a_act),
        .out_act_valid(a_act_v), .out_psum(a_psum), .out_wt(a_wt),
        .out_wt_valid(a_wt_v), .shadow_full(a_full), .sat_flag(a_sat));

    pe_dbuf #(.ACT_W(8), .WEIGHT_W(8), .PSUM_W(16), .SIGNED(1), .SATURATE(1)) u_dut_b (
        .clk(clk), .reset(reset), .in_act(in_act), .in_act_valid(in_act_valid),
        .in_psum(in_psum[15:0]), .in_wt(in_wt), .in_wt_valid(in_wt_valid),
        .wt_capture(wt_capture), .wt_swap(wt_swap), .out_act(b_act),
        .out_act_valid(b_act_v), .out_psum(b_psum), .out_wt(b_wt),
        .out_wt_valid(b_wt_v), .shadow_full(b_full), .sat_flag(b_sat));

    pe_dbuf #(.ACT_W(8), .WEIGHT_W(8), .PSUM_W(16), .SIGNED(0), .SATURATE(1)) u_dut_c (
        .clk(clk), .reset(reset), .in_act(in_act), .in_act_valid(in_act_valid),
        .in_psum(in_psum[15:0]), .in_wt(in_wt), .in_wt_valid(in_wt_valid),
        .wt_capture(wt_capture), .wt_swap(wt_swap), .out_act(c_act),
        .out_act_valid(c_act_v), .out_psum(c_psum), .out_wt(c_wt),
        .out_wt_valid(c_wt_v), .shadow_full(c_full), .sat_flag(c_sat));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Plain-integer MAC: exact result, then wrap or clamp into pw bits.
    function automatic void mac_model(input int pw, input bit sgn, input bit sat,
                                      input logic [7:0] act, input logic [7:0] wt,
                                      input logic [31:0] psum,
                                      output logic [31:0] res, output logic flag);
        longint a, w, p, r, modv, maxv, minv;
        modv = longint'(1) << pw;
        p    = longint'(psum) & (modv - 1);
        if (sgn) begin
            a = longint'($signed(act));
            w = longint'($signed(wt));
            if (p >= modv / 2) p = p - modv;
            maxv = modv / 2 - 1;
            minv = -(modv / 2);
        end else begin
            a = longint'(act);
            w = longint'(wt);
            maxv = modv - 1;
            minv = 0;
        end
        r    = a * w + p;
        flag = 1'b0;
        if (sat) begin
            if (r > maxv) begin r = maxv; flag = 1'b1; end
            else if (r < minv) begin r = minv; flag = 1'b1; end
        end
        res = 32'(r & (modv - 1));
    endfunction

    task automatic step(input string tag);
        logic [31:0] ea, eb, ec;
        logic        fa, fb, fc;
        logic [7:0]  e_act;
        logic        e_act_v;
        logic [7:0]  e_wt;
        logic        e_wt_v;
        if (in_act_valid) begin
            mac_model(32, 1'b1, 1'b0, in_act, m_active, in_psum, ea, fa);
            mac_model(16, 1'b1, 1'b1, in_act, m_active, in_psum, eb, fb);
            mac_model(16, 1'b0, 1'b1, in_act, m_active, in_psum, ec, fc);
            e_act = in_act;
        end else begin
            ea = in_psum;
            eb = {16'h0, in_psum[15:0]};
            ec = {16'h0, in_psum[15:0]};
            fa = 1'b0; fb = 1'b0; fc = 1'b0;
            e_act = 8'h0;
        end
        e_act_v = in_act_valid;
        e_wt    = in_wt;
        e_wt_v  = in_wt_valid;
        if (wt_swap && m_full) m_active = m_shadow;
        if (in_wt_valid && wt_capture) begin
            m_shadow = in_wt;
            m_full   = 1'b1;
        end else if (wt_swap) begin
            m_full   = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ":a_psum"}, a_psum, ea);
        chk({tag, ":b_psum"}, {16'h0, b_psum}, eb);
        chk({tag, ":c_psum"}, {16'h0, c_psum}, ec);
        chk({tag, ":a_sat"}, {31'h0, a_sat}, {31'h0, fa});
        chk({tag, ":b_sat"}, {31'h0, b_sat}, {31'h0, fb});
        chk({tag, ":c_sat"}, {31'h0, c_sat}, {31'h0, fc});
        chk({tag, ":act"}, {24'h0, a_act}, {24'h0, e_act});
        chk({tag, ":act_v"}, {31'h0, a_act_v}, {31'h0, e_act_v});
        chk({tag, ":wt"}, {24'h0, a_wt}, {24'h0, e_wt});
        chk({tag, ":wt_v"}, {31'h0, a_wt_v}, {31'h0, e_wt_v});
        chk({tag, ":full"}, {29'h0, a_full, b_full, c_full}, {29'h0, {3{m_full}}});
    endtask

    task automatic drive(input logic [7:0] act, input logic av, input logic [31:0] ps,
                         input logic [7:0] wt, input logic wv, input logic cap,
                         input logic swp);
        in_act = act; in_act_valid = av; in_psum = ps;
        in_wt = wt; in_wt_valid = wv; wt_capture = cap; wt_swap = swp;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ":a_psum"}, a_psum, 32'h0);
        chk({tag, ":bc_psum"}, {b_psum, c_psum}, 32'h0);
        chk({tag, ":act"}, {24'h0, a_act}, 32'h0);
        chk({tag, ":wt"}, {24'h0, a_wt}, 32'h0);
        chk({tag, ":flags"}, {25'h0, a_act_v, a_wt_v, a_full, b_full, c_full, a_sat, b_sat},
            32'h0);
        chk({tag, ":c_sat"}, {31'h0, c_sat}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        drive(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        m_active = 8'd0; m_shadow = 8'd0; m_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Idle PE with zero weight just forwards psum and activation
        drive(8'd5, 1'b1, 32'd7, 8'd0, 1'b0, 1'b0, 1'b0);  step("idle_mac");
        chk("idle_psum_7", a_psum, 32'd7);

        // Load 3 and swap; swap cycle still uses old weight
        drive(8'd0, 1'b0, 32'd0, 8'd3, 1'b1, 1'b1, 1'b0);  step("cap3");
        drive(8'd4, 1'b1, 32'd10, 8'd0, 1'b0, 1'b0, 1'b1); step("swap3");
        chk("swap_cycle_psum_10", a_psum, 32'd10);
        drive(8'd4, 1'b1, 32'd10, 8'd0, 1'b0, 1'b0, 1'b0); step("use3");
        chk("after_swap_psum_22", a_psum, 32'd22);

        // Double buffer: compute with 2 while 9 loads behind it
        drive(8'd0, 1'b0, 32'd0, 8'd2, 1'b1, 1'b1, 1'b0);  step("cap2");
        drive(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);  step("swap2");
        drive(8'd1, 1'b1, 32'd0, 8'd9, 1'b1, 1'b1, 1'b0);  step("db1");
        drive(8'd2, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);  step("db2");
        drive(8'd3, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);  step("db3");
        chk("db3_psum_6", a_psum, 32'd6);
        drive(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);  step("swap9");
        drive(8'd1, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);  step("empty_swap");
        drive(8'd1, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0, 0);     step("still9");
        chk("still9_psum", a_psum, 32'd9);

        // Capture 8 and swap in the same cycle with shadow holding 6
        drive(8'd0, 1'b0, 32'd0, 8'd6, 1'b1, 1'b1, 1'b0);  step("cap6");
        drive(8'd0, 1'b0, 32'd0, 8'd8, 1'b1, 1'b1, 1'b1);  step("cap8_swap");
        drive(8'd1, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);  step("use6");
        chk("active6_psum", a_psum, 32'd6);
        drive(8'd1, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);  step("swap8");
        drive(8'd1, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);  step("use8");
        chk("active8_psum", a_psum, 32'd8);

        // -128 * -128 + 32767 overflows 16-bit signed range
        drive(8'd0, 1'b0, 32'd0, 8'h80, 1'b1, 1'b1, 1'b0); step("cap_m128");
        drive(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);  step("swap_m128");
        drive(8'h80, 1'b1, 32'd32767, 8'd0, 1'b0, 1'b0, 1'b0); step("sat");
        chk("sat_b_psum", {16'h0, b_psum}, 32'd32767);
        chk("sat_b_flag", {31'h0, b_sat}, 32'd1);

        // Bubble passes psum untouched
        drive(8'h55, 1'b0, 32'h1234, 8'd0, 1'b0, 1'b0, 1'b0); step("bubble");
        chk("bubble_psum", a_psum, 32'h1234);

        for (int i = 0; i < 400; i++) begin
            drive(8'($urandom), ($urandom_range(0, 3) != 0), $urandom,
                  8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0));
            step("rand");
        end

        // Async reset between edges clears everything without a clock
        drive(8'd7, 1'b1, 32'h1234, 8'd5, 1'b1, 1'b1, 1'b0);
        step("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        m_active = 8'd0; m_shadow = 8'd0; m_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        drive(8'd7, 1'b1, 32'd3, 8'd0, 1'b0, 1'b0, 1'b1);
        step("post_reset");
        chk("post_reset_psum", a_psum, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
